// File: rtl/bus_transfer_ctrl_pkg.sv
// Shared encodings for the bus transfer control unit: FSM states, operation
// codes and bus-select codes.
package bus_transfer_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_XFER0 = 3'd1;
    localparam logic [STATE_W-1:0] ST_XFER1 = 3'd2;
    localparam logic [STATE_W-1:0] ST_XFER2 = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    localparam logic OP_MOVE = 1'b0;
    localparam logic OP_SWAP = 1'b1;

    localparam logic BUS_1 = 1'b0;
    localparam logic BUS_2 = 1'b1;

endpackage

// File: rtl/onehot_decoder.sv
// Gated index-to-one-hot decoder. An index outside 0..NREGS-1 or a low gate
// yields an all-zero vector, so at most one bit is ever set.
module onehot_decoder #(
    parameter int IDXW  = 3,
    parameter int NREGS = 8
) (
    input  logic [IDXW-1:0]  idx,
    input  logic             gate,
    output logic [NREGS-1:0] onehot
);

    // Compare the index against every register position.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = gate && (idx == IDXW'(i));
        end
    end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Bus transfer controller: accepts MOVE/SWAP requests and sequences the
// per-register load and bus output-enable strobes. SWAP goes through the
// reserved temp register (index NREGS-1). Strobes are decoded purely from the
// FSM state and the captured request.
module bus_transfer_ctrl
    import bus_transfer_ctrl_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int IDXW  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic             req_bus,
    input  logic [IDXW-1:0]  req_src,
    input  logic [IDXW-1:0]  req_dst,
    output logic [NREGS-1:0] load,
    output logic [NREGS-1:0] enable1,
    output logic [NREGS-1:0] enable2,
    output logic             done,
    output logic             err
);

    localparam logic [IDXW-1:0] TMP_IDX   = IDXW'(NREGS - 1);
    localparam logic [IDXW:0]   NREGS_EXT = (IDXW + 1)'(NREGS);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               cap_op;
    logic               cap_bus;
    logic [IDXW-1:0]    cap_src;
    logic [IDXW-1:0]    cap_dst;

    logic               accept;
    logic               xfer;
    logic [IDXW-1:0]    from_idx;
    logic [IDXW-1:0]    to_idx;

    // A request is rejected when an index is out of range, or when a SWAP
    // would use the temp register as one of its operands.
    function automatic logic is_bad(input logic op, input logic [IDXW-1:0] src,
                                    input logic [IDXW-1:0] dst);
        return ({1'b0, src} >= NREGS_EXT) || ({1'b0, dst} >= NREGS_EXT) ||
               ((op == OP_SWAP) && ((src == TMP_IDX) || (dst == TMP_IDX)));
    endfunction

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign done      = (state == ST_DONE);
    assign err       = done && is_bad(cap_op, cap_src, cap_dst);

    // Next-state selection; bad and no-op requests jump straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_bad(req_op, req_src, req_dst) || (req_src == req_dst)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_XFER0;
                    end
                end
            end
            ST_XFER0: state_nxt = (cap_op == OP_SWAP) ? ST_XFER1 : ST_DONE;
            ST_XFER1: state_nxt = ST_XFER2;
            ST_XFER2: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register and request capture at acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the captured request is reset as well, so err decodes to a known value from the first cycle.
            state   <= ST_IDLE;
            cap_op  <= OP_MOVE;
            cap_bus <= BUS_1;
            cap_src <= '0;
            cap_dst <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            if (accept) begin
                cap_op  <= req_op;
                cap_bus <= req_bus;
                cap_src <= req_src;
                cap_dst <= req_dst;
            end
        end
    end

    // Pick the driving and loading register for the current transfer step.
    always_comb begin
        xfer     = 1'b0;
        from_idx = cap_src;
        to_idx   = cap_dst;
        case (state)
            ST_XFER0: begin
                xfer     = 1'b1;
                from_idx = cap_src;
                to_idx   = (cap_op == OP_SWAP) ? TMP_IDX : cap_dst;
            end
            ST_XFER1: begin
                xfer     = 1'b1;
                from_idx = cap_dst;
                to_idx   = cap_src;
            end
            ST_XFER2: begin
                xfer     = 1'b1;
                from_idx = TMP_IDX;
                to_idx   = cap_dst;
            end
            default: begin
                xfer = 1'b0;
            end
        endcase
    end

    onehot_decoder #(.IDXW(IDXW), .NREGS(NREGS)) u_load_dec (
        .idx    (to_idx),
        .gate   (xfer),
        .onehot (load)
    );

    onehot_decoder #(.IDXW(IDXW), .NREGS(NREGS)) u_en1_dec (
        .idx    (from_idx),
        .gate   (xfer && (cap_bus == BUS_1)),
        .onehot (enable1)
    );

    onehot_decoder #(.IDXW(IDXW), .NREGS(NREGS)) u_en2_dec (
        .idx    (from_idx),
        .gate   (xfer && (cap_bus == BUS_2)),
        .onehot (enable2)
    );

endmodule

// File: doc/bus_transfer_ctrl.md
BUS_TRANSFER_CTRL -- requirements
Module: bus_transfer_ctrl

Interface
REQ-001 SHALL have parameter NREGS, default 8: number of dual-output bus registers controlled; index NREGS-1 is the reserved temp register TMP.
REQ-002 SHALL have parameter IDXW, default 3: register index width, with NREGS <= 2**IDXW.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  transfer request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_op  input  1  operation: 0 = MOVE, 1 = SWAP.
REQ-008 SHALL have port req_bus  input  1  bus select: 0 = bus1 (enable1), 1 = bus2 (enable2).
REQ-009 SHALL have port req_src  input  IDXW  source register index.
REQ-010 SHALL have port req_dst  input  IDXW  destination register index.
REQ-011 SHALL have port load  output  NREGS  one-hot per-register load strobe.
REQ-012 SHALL have port enable1  output  NREGS  per-register bus1 output enable.
REQ-013 SHALL have port enable2  output  NREGS  per-register bus2 output enable.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err  output  1  error qualifier, valid only while done=1.

Function
REQ-016 SHALL implement states IDLE, XFER0, XFER1, XFER2, DONE.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-018 SHALL capture op, bus, src and dst at acceptance and ignore request inputs until the next return to IDLE.
REQ-019 SHALL perform MOVE as one transfer cycle (XFER0): enable[src]=1 on the selected bus and load[dst]=1, then DONE.
REQ-020 SHALL perform SWAP as three transfer cycles: XFER0 TMP<-src, XFER1 src<-dst, XFER2 dst<-TMP, then DONE.
REQ-021 SHALL assert at most one bit of enable1, at most one of enable2, and at most one of load in any cycle; the unselected bus enable vector SHALL be all-zero.
REQ-022 SHALL hold load, enable1 and enable2 at zero in IDLE and DONE.
REQ-023 SHALL skip transfer states and go directly to DONE with err=0 when src==dst: no load or enable is asserted.
REQ-024 SHALL go directly to DONE with err=1 and no strobes when src or dst >= NREGS, or when the op is SWAP and src or dst == TMP.
REQ-025 SHALL assert done for exactly one cycle in DONE and then return to IDLE; a new request can be accepted no earlier than the cycle after DONE.
REQ-026 SHALL give latency from acceptance edge to done: MOVE 2 cycles, SWAP 4 cycles, no-op or error 1 cycle.
REQ-027 SHALL allow a MOVE with dst == TMP.
REQ-028 SHALL drive err=0 whenever done=0.

Reset
REQ-029 SHALL, while reset=0, force state IDLE and force load, enable1, enable2, done and err to 0, independent of clock.
REQ-030 SHALL abandon a transfer in progress when reset is asserted mid-operation, with no further strobes and no done pulse.
REQ-031 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-032 SHALL take the op encodings (MOVE, SWAP), bus-select encodings and state encodings from a shared package or header used by the control-unit blocks.
REQ-033 SHALL use one sub-module, onehot_decoder (IDXW in, NREGS one-hot out, with a gate input), for the load and enable vector generation.
REQ-034 SHALL keep the state and captured request as the only registers; all strobes SHALL be decoded from them.

Verification
REQ-035 SHALL cover MOVE src=2, dst=5, bus1: exactly one cycle with enable1=8'h04 and load=8'h20, enable2=0, and done 2 cycles after acceptance.
REQ-036 SHALL cover SWAP src=1, dst=3, bus2, with NREGS=8:
- cycle 1: enable2=02, load=80
- cycle 2: enable2=08, load=02
- cycle 3: enable2=80, load=08
- then done=1, err=0.
REQ-037 SHALL cover SWAP src=7 and MOVE src=4, dst=4: no strobes, done after 1 cycle, with err=1 and err=0 respectively.
REQ-038 SHALL cover reset asserted during XFER1 of a SWAP: all outputs are 0 immediately, no done pulse, and req_ready=1 after release.
REQ-039 SHALL cover back-to-back requests with req_valid held high: req_ready is low from acceptance through DONE, the second request is accepted in the IDLE cycle after done, and the one-hot invariants hold in every cycle.
